// File: rtl/lv_hv_shadow_rd_req.sv
// LV-side OWT read-request sequencer.
// Polls the HV shadowed registers in a fixed round-robin list, one read in
// flight at a time, with per-address retries, a response timeout, a saturating
// error counter and a round-completion pulse. Response data itself is consumed
// by the shadow bank; this block only judges pass/fail of each response.
module lv_hv_shadow_rd_req #(
  parameter int OWT_CMD_BIT_NUM  = 8,
  parameter int OWT_ADCD_BIT_NUM = 20,
  parameter int POLL_GAP_CYC     = 64,
  parameter int RSP_TIMEOUT_CYC  = 255,
  parameter int MAX_RETRY        = 2,
  parameter int ERR_CNT_W        = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_poll_en,
  output logic                        o_owt_tx_req,
  output logic [OWT_CMD_BIT_NUM-1:0]  o_owt_tx_cmd,
  output logic [OWT_ADCD_BIT_NUM-1:0] o_owt_tx_data,
  input  logic                        i_owt_tx_ack,
  input  logic                        i_owt_rx_ack,
  input  logic [OWT_CMD_BIT_NUM-1:0]  i_owt_rx_cmd,
  input  logic                        i_owt_rx_status,
  output logic                        o_poll_busy,
  output logic                        o_rsp_err,
  output logic [ERR_CNT_W-1:0]        o_err_cnt,
  output logic                        o_round_done
);

  localparam int ADDR_W = OWT_CMD_BIT_NUM - 1;
  localparam int GAP_W  = $clog2(POLL_GAP_CYC + 1);
  localparam int TMO_W  = $clog2(RSP_TIMEOUT_CYC + 1);
  localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RSP_TIMEOUT_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [2:0]       IDX_LAST = 3'd6;

  typedef enum logic [1:0] {IDLE, GAP, REQ, WAIT_RSP} state_e;

  state_e                       state_q, state_d;
  logic [GAP_W-1:0]             gap_cnt_q, gap_cnt_d;
  logic [TMO_W-1:0]             tmo_cnt_q, tmo_cnt_d;
  logic [2:0]                   idx_q, idx_d;
  logic [RTY_W-1:0]             rty_q, rty_d;
  logic                         tx_req_q, tx_req_d;
  logic [OWT_CMD_BIT_NUM-1:0]   tx_cmd_q, tx_cmd_d;
  logic                         rsp_err_q, rsp_err_d;
  logic [ERR_CNT_W-1:0]         err_cnt_q, err_cnt_d;
  logic                         round_done_q, round_done_d;
  logic                         busy_q, busy_d;
  logic                         txn_end, txn_ok;
  logic [ADDR_W-1:0]            cur_addr;

  // Fixed poll list; index 6 is the last entry of a round.
  function automatic logic [ADDR_W-1:0] list_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    list_addr = ADDR_W'(7'h08);
      3'd1:    list_addr = ADDR_W'(7'h0A);
      3'd2:    list_addr = ADDR_W'(7'h0C);
      3'd3:    list_addr = ADDR_W'(7'h0D);
      3'd4:    list_addr = ADDR_W'(7'h14);
      3'd5:    list_addr = ADDR_W'(7'h15);
      3'd6:    list_addr = ADDR_W'(7'h1F);
      default: list_addr = ADDR_W'(7'h08);
    endcase
  endfunction

  assign cur_addr = list_addr(idx_q);

  // Next-state, counters and registered-output values for the poll sequencer.
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    idx_d        = idx_q;
    rty_d        = rty_q;
    tx_req_d     = tx_req_q;
    tx_cmd_d     = tx_cmd_q;
    rsp_err_d    = 1'b0;
    err_cnt_d    = err_cnt_q;
    round_done_d = 1'b0;
    txn_end      = 1'b0;
    txn_ok       = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_poll_en) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end
      end
      GAP: begin
        if (!i_poll_en) begin
          state_d = IDLE;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d  = REQ;
          tx_req_d = 1'b1;
          tx_cmd_d = {1'b0, cur_addr};
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      // Poll enable is deliberately ignored once a request is out.
      REQ: begin
        if (i_owt_tx_ack) begin
          state_d   = WAIT_RSP;
          tx_req_d  = 1'b0;
          tmo_cnt_d = '0;
        end
      end
      WAIT_RSP: begin
        // A response landing on the timeout cycle wins over the timeout.
        if (i_owt_rx_ack) begin
          txn_end = 1'b1;
          txn_ok  = !i_owt_rx_status && (i_owt_rx_cmd == {1'b1, cur_addr});
        end else if (tmo_cnt_q == TMO_LAST) begin
          txn_end = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (txn_end) begin
      if (txn_ok || rty_q == RTY_MAX) begin
        rty_d        = '0;
        idx_d        = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        round_done_d = (idx_q == IDX_LAST);
        if (!txn_ok) begin
          rsp_err_d = 1'b1;
          if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
        end
      end else begin
        rty_d = rty_q + 1'b1;
      end
      state_d   = i_poll_en ? GAP : IDLE;
      gap_cnt_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any in-flight request immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      idx_q        <= '0;
      rty_q        <= '0;
      tx_req_q     <= 1'b0;
      tx_cmd_q     <= '0;
      rsp_err_q    <= 1'b0;
      err_cnt_q    <= '0;
      round_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      idx_q        <= idx_d;
      rty_q        <= rty_d;
      tx_req_q     <= tx_req_d;
      tx_cmd_q     <= tx_cmd_d;
      rsp_err_q    <= rsp_err_d;
      err_cnt_q    <= err_cnt_d;
      round_done_q <= round_done_d;
      busy_q       <= busy_d;
    end
  end

  assign o_owt_tx_req  = tx_req_q;
  assign o_owt_tx_cmd  = tx_cmd_q;
  assign o_owt_tx_data = '0;
  assign o_poll_busy   = busy_q;
  assign o_rsp_err     = rsp_err_q;
  assign o_err_cnt     = err_cnt_q;
  assign o_round_done  = round_done_q;

endmodule

// File: tb/tb_lv_hv_shadow_rd_req.sv
// Directed bench for lv_hv_shadow_rd_req with default parameters.
module tb_lv_hv_shadow_rd_req;

  localparam int M_OK  = 0;  // matching response, status 0
  localparam int M_ST  = 1;  // response with frame-error status
  localparam int M_CMD = 2;  // response with cmd 0x8A
  localparam int M_TMO = 3;  // no response at all

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        poll_en = 1'b0;
  logic        tx_req;
  logic [7:0]  tx_cmd;
  logic [19:0] tx_data;
  logic        tx_ack = 1'b0;
  logic        rx_ack = 1'b0;
  logic [7:0]  rx_cmd = 8'h00;
  logic        rx_status = 1'b0;
  logic        busy;
  logic        rsp_err;
  logic [7:0]  err_cnt;
  logic        round_done;

  int n_vec = 0;
  int n_bad = 0;
  int rd_seen = 0;
  int err_seen = 0;
  int rd_exp = 0;
  int eidx = 0;

  lv_hv_shadow_rd_req dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_poll_en       (poll_en),
    .o_owt_tx_req    (tx_req),
    .o_owt_tx_cmd    (tx_cmd),
    .o_owt_tx_data   (tx_data),
    .i_owt_tx_ack    (tx_ack),
    .i_owt_rx_ack    (rx_ack),
    .i_owt_rx_cmd    (rx_cmd),
    .i_owt_rx_status (rx_status),
    .o_poll_busy     (busy),
    .o_rsp_err       (rsp_err),
    .o_err_cnt       (err_cnt),
    .o_round_done    (round_done)
  );

  always #5 clk = ~clk;

  // Count single-cycle pulses as seen by the clock.
  always @(posedge clk) begin
    if (round_done) rd_seen++;
    if (rsp_err)    err_seen++;
  end

  function automatic logic [6:0] lst(input int i);
    case (i)
      0: lst = 7'h08;
      1: lst = 7'h0A;
      2: lst = 7'h0C;
      3: lst = 7'h0D;
      4: lst = 7'h14;
      5: lst = 7'h15;
      default: lst = 7'h1F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance the bench's model of the list index after an address completes.
  task automatic advance();
    if (eidx == 6) begin
      eidx = 0;
      rd_exp++;
    end else begin
      eidx++;
    end
  endtask

  // One request/response exchange: tx_ack 2 cycles after req, response 10 after ack.
  task automatic txn(input logic [6:0] addr, input int mode);
    int n = 0;
    while (!tx_req && n < 1000) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(tx_req), 32'd1);
    chk("tx_cmd", 32'(tx_cmd), 32'({1'b0, addr}));
    chk("tx_data", 32'(tx_data), 32'd0);
    tick();
    tick();
    chk("req_hold", 32'(tx_req), 32'd1);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    chk("req_drop", 32'(tx_req), 32'd0);
    if (mode != M_TMO) begin
      repeat (9) tick();
      rx_ack    = 1'b1;
      rx_status = (mode == M_ST);
      rx_cmd    = (mode == M_CMD) ? 8'h8A : {1'b1, addr};
      tick();
      rx_ack    = 1'b0;
      rx_status = 1'b0;
      rx_cmd    = 8'h00;
    end
  endtask

  initial begin
    int n;
    // Reset state
    #3;
    chk("rst_req", 32'(tx_req), 32'd0);
    chk("rst_cmd", 32'(tx_cmd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    chk("rst_done", 32'(round_done), 32'd0);
    #20;
    rst_n = 1'b1;
    tick();
    repeat (5) tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_noreq", 32'(tx_req), 32'd0);

    // 1: one full clean round
    poll_en = 1'b1;
    tick();
    tick();
    chk("busy_on", 32'(busy), 32'd1);
    for (int i = 0; i < 7; i++) begin
      txn(lst(eidx), M_OK);
      advance();
      if (i == 5) begin
        tick();
        chk("no_early_done", 32'(rd_seen), 32'd0);
      end
    end
    tick();
    chk("round1_done", 32'(rd_seen), 32'd1);
    chk("round1_err", 32'(err_cnt), 32'd0);

    // 4: wrong response cmd on 0x08 is a fail, 0x08 re-issued
    txn(7'h08, M_CMD);
    txn(7'h08, M_OK);
    advance();

    // 2: 0x0A ok, then 0x0C times out three times
    txn(7'h0A, M_OK);
    advance();
    for (int a = 0; a < 3; a++) begin
      txn(7'h0C, M_TMO);
      n = 0;
      if (a < 2) begin
        while (!tx_req && n < 1000) begin
          tick();
          n++;
        end
        chk("tmo_to_req", 32'(n), 32'd319);
        chk("tmo_no_err", 32'(err_seen), 32'd0);
      end else begin
        while (!rsp_err && n < 1000) begin
          tick();
          n++;
        end
        chk("tmo_to_err", 32'(n), 32'd255);
        chk("tmo_errcnt", 32'(err_cnt), 32'd1);
      end
    end
    advance();
    tick();
    chk("tmo_err_pulses", 32'(err_seen), 32'd1);
    for (int i = 0; i < 4; i++) begin
      txn(lst(eidx), M_OK);
      advance();
    end
    tick();
    chk("round2_done", 32'(rd_seen), 32'(rd_exp));

    // 3: status error on 0x08, re-issue, then advance to 0x0A
    txn(7'h08, M_ST);
    txn(7'h08, M_OK);
    advance();
    txn(7'h0A, M_OK);
    advance();
    tick();
    chk("st_no_err", 32'(err_seen), 32'd1);
    chk("st_errcnt", 32'(err_cnt), 32'd1);

    // 5: drop poll_en while in REQ; transaction still completes, then IDLE
    n = 0;
    while (!tx_req && n < 1000) begin
      tick();
      n++;
    end
    poll_en = 1'b0;
    txn(7'h0C, M_OK);
    advance();
    chk("drop_busy", 32'(busy), 32'd0);
    n = 0;
    repeat (100) begin
      tick();
      if (tx_req || busy) n++;
    end
    chk("drop_quiet", 32'(n), 32'd0);
    poll_en = 1'b1;
    txn(7'h0D, M_OK);
    advance();
    // drop poll_en inside GAP: back to IDLE, index kept
    repeat (10) tick();
    poll_en = 1'b0;
    tick();
    chk("gap_drop_busy", 32'(busy), 32'd0);
    n = 0;
    repeat (100) begin
      tick();
      if (tx_req) n++;
    end
    chk("gap_drop_noreq", 32'(n), 32'd0);
    poll_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      txn(lst(eidx), M_OK);
      advance();
    end
    tick();
    chk("round3_done", 32'(rd_seen), 32'(rd_exp));

    // 6: 256 retry-exhausted addresses, counter saturates at 0xFF
    for (int k = 0; k < 256; k++) begin
      repeat (3) txn(lst(eidx), M_ST);
      advance();
      if (k == 253) begin
        tick();
        chk("sat_reach", 32'(err_cnt), 32'hFF);
      end
    end
    tick();
    chk("sat_hold", 32'(err_cnt), 32'hFF);
    chk("sat_pulses", 32'(err_seen), 32'd257);
    chk("sat_rounds", 32'(rd_seen), 32'(rd_exp));

    // async reset in the middle of WAIT_RSP
    txn(lst(eidx), M_TMO);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(tx_req), 32'd0);
    chk("arst_cmd", 32'(tx_cmd), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_errcnt", 32'(err_cnt), 32'd0);
    chk("arst_rsp_err", 32'(rsp_err), 32'd0);
    chk("arst_done", 32'(round_done), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    txn(7'h08, M_OK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
